// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARBITER_FIXED_PRIO_EN for fixed priority (port 0 wins ties, no round-robin pointer).
module alu_arbiter #(
    parameter int MUL_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_a,
    input  logic [5:0]  req0_b,
    input  logic [1:0]  req0_sel,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_a,
    input  logic [5:0]  req1_b,
    input  logic [1:0]  req1_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [11:0] rsp_result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam logic [2:0] MUL_LAST = 3'(MUL_WAIT);
    state_t state, state_next;
    logic [5:0] a_q, b_q;
    logic [1:0] sel_q;
    logic id_q;
    logic [2:0] cnt;
    logic pick0, accept, done;
    logic [11:0] alu;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    assign pick0 = req0_valid;
`else
    // last: 1 when port 1 won the most recent accept, so port 0 wins the next tie
    logic last;
    assign pick0 = req0_valid && (!req1_valid || last);
    always_ff @(posedge clk)
        if (rst) last <= 1'b1;
        else if (accept) last <= req1_ready;
`endif

    assign req0_ready = state == IDLE && !rst && pick0;
    assign req1_ready = state == IDLE && !rst && req1_valid && !pick0;
    assign accept = req0_ready || req1_ready;
    assign done = sel_q != 2'b10 || cnt == MUL_LAST;
    assign rsp_valid = state == RESP;
    assign busy = state != IDLE;
    assign alu = sel_q == 2'b00 ? {6'b0, a_q + b_q} :
                 sel_q == 2'b01 ? {6'b0, a_q - b_q} :
                 sel_q == 2'b10 ? {6'b0, a_q} * {6'b0, b_q} :
                                  {6'b0, a_q & b_q};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? EXEC : IDLE;
            EXEC:    state_next = done ? RESP : EXEC;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            id_q       <= 1'b0;
            cnt        <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
        end else begin
            if (accept) begin
                a_q   <= req1_ready ? req1_a : req0_a;
                b_q   <= req1_ready ? req1_b : req0_b;
                sel_q <= req1_ready ? req1_sel : req0_sel;
                id_q  <= req1_ready;
                cnt   <= '0;
            end
            if (state == EXEC) begin
                if (done) begin
                    rsp_result <= alu;
                    rsp_id     <= id_q;
                end else begin
                    cnt <= cnt + 3'd1;
                end
            end
        end
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: MUL_WAIT, 1, extra EXEC cycles for multiply (sel=2'b10), range 0..7.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  input  1  requester has an operation pending.
REQ-005 SHALL have ports: req0_ready / req1_ready  output  1  arbiter accepts that requester's operation this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  input  6  operands.
REQ-007 SHALL have ports: req0_sel / req1_sel  input  2  op: 00 add, 01 sub, 10 mul, 11 and.
REQ-008 SHALL have port: rsp_valid  output  1  response holds a completed result.
REQ-009 SHALL have port: rsp_ready  input  1  consumer takes the response.
REQ-010 SHALL have port: rsp_id  output  1  requester index of the response.
REQ-011 SHALL have port: rsp_result  output  12  result (add/sub/and zero-extended from 6 bits; mul full 12 bits).
REQ-012 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL instantiate a single ALU datapath shared by both requesters, with operands driven only from internally latched registers.
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-015 In IDLE, SHALL assert reqN_ready combinationally only for the granted port; a handshake occurs on reqN_valid && reqN_ready.
REQ-016 On handshake, SHALL latch a, b, sel and id, and go to EXEC next cycle.
REQ-017 With one valid requester, SHALL grant it; with both valid, SHALL grant the port not granted at the last accept (round-robin).
REQ-018 SHALL update the round-robin pointer only on an accepted handshake.
REQ-019 EXEC SHALL last 1 cycle for add/sub/and and 1+MUL_WAIT cycles for mul, counted by an internal 3-bit counter.
REQ-020 On the final EXEC cycle, SHALL register the ALU result into rsp_result and go to RESP.
REQ-021 In RESP, SHALL assert rsp_valid; rsp_id and rsp_result SHALL stay stable until rsp_ready.
REQ-022 On rsp_valid && rsp_ready, SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-023 Latency: accept at cycle t, rsp_valid at t+2 (non-mul) or t+2+MUL_WAIT (mul).
REQ-024 Sub SHALL wrap modulo 64 (A-B), with no borrow output.
REQ-025 In EXEC and RESP, both reqN_ready SHALL be 0 regardless of reqN_valid.
REQ-026 Requester input changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-027 While rst is high at a clock edge, SHALL enter IDLE and clear the counter and latched operands.
REQ-028 Reset values: rsp_valid=0, rsp_id=0, rsp_result=12'h000, busy=0, round-robin pointer pointing at port 1 as last granted (port 0 wins first tie).
REQ-029 Reset mid-EXEC or mid-RESP SHALL discard the in-flight operation, with no response emitted.
REQ-030 reqN_ready SHALL be 0 during any cycle in which rst is high.

Configuration
REQ-031 Macro ALU_ARBITER_FIXED_PRIO_EN: when defined, SHALL use fixed priority (port 0 always wins ties) and omit the round-robin pointer.
REQ-032 Without ALU_ARBITER_FIXED_PRIO_EN, SHALL use round-robin per REQ-017/018.

Verification
REQ-033 Port0 add a=5 b=3 accepted at t -> rsp_valid at t+2, rsp_id=0, rsp_result=12'h008.
REQ-034 Port1 mul a=63 b=63, MUL_WAIT=1, accepted at t -> rsp_valid at t+3, rsp_id=1, rsp_result=12'hF81.
REQ-035 Port0 sub a=3 b=5 -> rsp_result=12'h03E; port0 and a=6'h2A b=6'h0F -> 12'h00A.
REQ-036 Both ports valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,0,1; with ALU_ARBITER_FIXED_PRIO_EN -> 0,0,0,0.
REQ-037 rsp_ready low for 3 cycles in RESP -> rsp_valid, rsp_id and rsp_result held constant, both reqN_ready=0, busy=1.
REQ-038 rst pulsed for 1 cycle during EXEC of a mul -> no rsp_valid; next cycle IDLE, busy=0, and a new port0 request is accepted.
